easyaxi_mem_slv: RTL and testbench
==================================

Name: easyaxi_mem_slv

Overview:
AXI4 memory-backed responder (slave) that answers the EasyAXI master inside the top-level design. It accepts AW/W/B write bursts and AR/R read bursts into an internal word array, with one outstanding transaction per direction. The read and write paths are independent FSMs. It provides the responder end that the master's enable/done test sequence exercises.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; power of two, at least 8
ID_WIDTH, 4, AXI ID width
MEM_DEPTH, 64, number of DATA_WIDTH words; power of two

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
awvalid/awready  in/out  1/1  write-address handshake
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  write beats minus 1
awsize  in  3  write beat size
awburst  in  2  write burst type
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wlast  in  1  last write beat
bvalid/bready  out/in  1/1  write-response handshake
bid  out  ID_WIDTH  echoed awid
bresp  out  2  write response
arvalid/arready  in/out  1/1  read-address handshake
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  read beats minus 1
arsize  in  3  read beat size
arburst  in  2  read burst type
rvalid/rready  out/in  1/1  read-data handshake
rid  out  ID_WIDTH  echoed arid
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat

Behaviour:
- Reset, synchronous on rst_n=0 at a clk edge: both FSMs go to IDLE; awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bresp, rresp, rdata, bid, rid=0. The memory array is not reset.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], where ADDR_LSB=log2(DATA_WIDTH/8). Address low bits are ignored.
- A beat is out-of-range if addr >= MEM_DEPTH*DATA_WIDTH/8.
- Burst is illegal if size != ADDR_LSB or burst == WRAP(2'b10) or burst == 2'b11.
- Address progression:
  - INCR: +DATA_WIDTH/8 per beat.
  - FIXED: address held for every beat.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst/legality, clear beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. On each W handshake:
    - Write mem if the burst is legal and the beat is in range; otherwise drop the write and set the error flag.
    - Also set the error flag if wlast != (cnt==len).
    - When cnt==len, go to W_RESP; otherwise cnt++ and advance address.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if error flag set, else OKAY(2'b00). Hold until bready, then W_IDLE.
  - Minimum AW-to-B latency: AW accept in cycle N, one-beat W in N+1, bvalid in N+2.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch fields and load rdata from mem[start] (registered). rvalid=1 next cycle.
  - R_DATA: rvalid held with rdata/rresp/rlast stable until rready.
    - rlast=1 on beat cnt==len.
    - rresp=SLVERR and rdata=0 for an illegal burst or out-of-range beat; otherwise OKAY.
    - On a non-last handshake: advance the address, reload rdata next cycle, rvalid stays 1 (back-to-back beats at full rate).
    - On the last handshake: rvalid=0, go to R_IDLE.
- Same-cycle write and read to the same word: the read register captures the old memory contents.
- Reset asserted mid-burst: both FSMs abort immediately to IDLE; no B or remaining R beats are issued; memory words already written stay written.

Optional Feature:
EASYAXI_MEM_SLV_WSTRB_EN
- Defined: only bytes with wstrb[i]=1 are written; other bytes keep their contents.
- Undefined: wstrb is ignored and the full word is written on every legal beat.

Test Plan:
- Single write then read: AW addr=0x10 len=0 INCR size=2 id=3, W 0xDEADBEEF wlast=1 -> bvalid with bid=3 bresp=OKAY. AR addr=0x10 -> rdata=0xDEADBEEF, rlast=1, rid=3, rresp=OKAY.
- INCR burst: write len=3 at 0x0 with data 1,2,3,4 -> one B OKAY. Read back len=3 with rready=1 -> rdata 1,2,3,4 on consecutive cycles, rlast only on the 4th beat.
- FIXED burst: write len=2 at 0x20 with data A,B,C -> mem[8]=C. Read FIXED len=1 at 0x20 -> C, C.
- Errors:
  - Write at 0x100 (out-of-range for depth 64) -> bresp=SLVERR, memory unchanged.
  - Read WRAP burst len=1 -> 2 beats, rresp=SLVERR, rdata=0.
  - Write len=1 with wlast on beat 0 -> bresp=SLVERR.
- Backpressure plus reset:
  - Hold rready=0 for 5 cycles mid-burst -> rdata/rlast stable.
  - Hold bready=0 -> bvalid held.
  - Assert rst_n=0 during beat 2 of a len=7 read -> next cycle rvalid=0, arready=1.
- Strobes with WSTRB_EN defined: mem=0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> read 0x11BB33DD. Without the macro -> read 0xAABBCCDD.

Source files
------------

// File: rtl/easyaxi_mem_slv.sv
// easyaxi_mem_slv: AXI4 memory-backed responder with independent read and write FSMs.
// Define EASYAXI_MEM_SLV_WSTRB_EN to honour wstrb byte enables; otherwise full words are written.
module easyaxi_mem_slv #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write path ----------------
  w_state_t              w_state_reg;
  logic [ID_WIDTH-1:0]   w_id_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic [7:0]            w_len_reg;
  logic [7:0]            w_cnt_reg;
  logic                  w_fixed_reg;
  logic                  w_legal_reg;
  logic                  w_err_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [ID_WIDTH-1:0]   bid_reg;

  logic                  w_fire;
  logic                  w_last_beat;
  logic                  w_in_range;
  logic                  w_mem_ok;
  logic                  w_mem_we;
  logic                  w_err_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [IDX_W-1:0]      w_idx;
  logic [NBYTES-1:0]     w_byte_en;

  assign w_fire      = wvalid && wready_reg;
  assign w_last_beat = (w_cnt_reg == w_len_reg);
  assign w_in_range  = (w_addr_reg >> (ADDR_LSB + IDX_W)) == '0;
  assign w_mem_ok    = w_legal_reg && w_in_range;
  assign w_err_next  = w_err_reg || !w_mem_ok || (wlast != w_last_beat);
  assign w_addr_next = w_fixed_reg ? w_addr_reg : w_addr_reg + ADDR_WIDTH'(NBYTES);
  assign w_idx       = w_addr_reg[ADDR_LSB +: IDX_W];
  // Writes are squashed while reset is asserted so an aborted burst stops immediately.
  assign w_mem_we    = rst_n && w_fire && w_mem_ok;

`ifdef EASYAXI_MEM_SLV_WSTRB_EN
  assign w_byte_en = wstrb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
  assign w_byte_en    = '1;
`endif

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (w_mem_we && w_byte_en[b]) begin
        mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      bid_reg     <= '0;
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_fixed_reg <= 1'b0;
      w_legal_reg <= 1'b0;
      w_err_reg   <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            w_id_reg    <= awid;
            w_addr_reg  <= awaddr;
            w_len_reg   <= awlen;
            w_cnt_reg   <= '0;
            w_fixed_reg <= (awburst == BURST_FIXED);
            w_legal_reg <= (awsize == 3'(ADDR_LSB)) &&
                           (awburst == BURST_FIXED || awburst == BURST_INCR);
            w_err_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err_reg <= w_err_next;
            if (w_last_beat) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bid_reg     <= w_id_reg;
              bresp_reg   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
              w_state_reg <= W_RESP;
            end else begin
              w_cnt_reg  <= w_cnt_reg + 8'd1;
              w_addr_reg <= w_addr_next;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            bid_reg     <= '0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: begin
          w_state_reg <= W_IDLE;
          awready_reg <= 1'b1;
          wready_reg  <= 1'b0;
          bvalid_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state_reg;
  logic [ID_WIDTH-1:0]   rid_reg;
  logic [ADDR_WIDTH-1:0] r_addr_reg;
  logic [7:0]            r_len_reg;
  logic [7:0]            r_cnt_reg;
  logic                  r_fixed_reg;
  logic                  r_legal_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic                  rlast_reg;
  logic [1:0]            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  r_start;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic [7:0]            r_cnt_next;
  logic                  r_legal_next;
  logic                  r_last_next;
  logic                  r_ld_ok;
  logic [IDX_W-1:0]      r_ld_idx;

  // The address feeding the read register: start address on AR, next beat otherwise.
  assign r_start      = (r_state_reg == R_IDLE) && arvalid;
  assign r_addr_next  = r_start ? araddr :
                        (r_fixed_reg ? r_addr_reg : r_addr_reg + ADDR_WIDTH'(NBYTES));
  assign r_cnt_next   = r_start ? 8'd0 : r_cnt_reg + 8'd1;
  assign r_legal_next = r_start ? ((arsize == 3'(ADDR_LSB)) &&
                                   (arburst == BURST_FIXED || arburst == BURST_INCR))
                                : r_legal_reg;
  assign r_last_next  = (r_cnt_next == (r_start ? arlen : r_len_reg));
  assign r_ld_ok      = r_legal_next && ((r_addr_next >> (ADDR_LSB + IDX_W)) == '0);
  assign r_ld_idx     = r_addr_next[ADDR_LSB +: IDX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
      rid_reg     <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_fixed_reg <= 1'b0;
      r_legal_reg <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            rid_reg     <= arid;
            r_addr_reg  <= r_addr_next;
            r_len_reg   <= arlen;
            r_cnt_reg   <= r_cnt_next;
            r_fixed_reg <= (arburst == BURST_FIXED);
            r_legal_reg <= r_legal_next;
            rdata_reg   <= r_ld_ok ? mem[r_ld_idx] : '0;
            rresp_reg   <= r_ld_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_reg   <= r_last_next;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            r_state_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              rresp_reg   <= RESP_OKAY;
              rdata_reg   <= '0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_addr_reg <= r_addr_next;
              r_cnt_reg  <= r_cnt_next;
              rdata_reg  <= r_ld_ok ? mem[r_ld_idx] : '0;
              rresp_reg  <= r_ld_ok ? RESP_OKAY : RESP_SLVERR;
              rlast_reg  <= r_last_next;
            end
          end
        end
        default: begin
          r_state_reg <= R_IDLE;
          arready_reg <= 1'b1;
          rvalid_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign awready = awready_reg;
  assign wready  = wready_reg;
  assign bvalid  = bvalid_reg;
  assign bid     = bid_reg;
  assign bresp   = bresp_reg;
  assign arready = arready_reg;
  assign rvalid  = rvalid_reg;
  assign rid     = rid_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;
  assign rlast   = rlast_reg;

endmodule

// File: tb/tb_easyaxi_mem_slv.sv
// Directed plus randomized bench for easyaxi_mem_slv against a word-array reference model.
module tb_easyaxi_mem_slv;
  localparam int AW = 32, DW = 32, IW = 4, DEPTH = 64, NB = DW / 8;
  localparam int MEM_BYTES = DEPTH * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [IW-1:0] awid = '0, arid = '0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, rlast;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  easyaxi_mem_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf [256];
  logic [NB-1:0] sbuf [256];
  logic [DW-1:0] rd_first;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ref(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
`ifdef EASYAXI_MEM_SLV_WSTRB_EN
    for (int b = 0; b < NB; b++)
      if (s[b]) ref_mem[a / NB][b*8 +: 8] = d[b*8 +: 8];
`else
    if (s !== 'x) ref_mem[a / NB] = d;
`endif
  endtask

  task automatic fill_buf(input int len, input logic [DW-1:0] base, input logic rnd);
    for (int k = 0; k <= len; k++) begin
      wbuf[k] = rnd ? DW'($urandom) : base + DW'(k);
      sbuf[k] = '1;
    end
  endtask

  task automatic axi_write(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input logic [2:0] size, input logic [1:0] burst,
                           input int bad_last, input int bstall);
    logic legal, err;
    logic [AW-1:0] a;
    legal = (size == 3'd2) && (burst == 2'b00 || burst == 2'b01);
    err = 1'b0;
    chk({tag, "_awready"}, awready, 1);
    awvalid = 1; awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    step();
    awvalid = 0;
    for (int k = 0; k <= len; k++) begin
      a = (burst == 2'b00) ? addr : addr + AW'(k * NB);
      wvalid = 1; wdata = wbuf[k]; wstrb = sbuf[k];
      wlast = (k == len) ^ (k == bad_last);
      if (k == bad_last) err = 1'b1;
      chk($sformatf("%s_wready%0d", tag, k), wready, 1);
      step();
      if (legal && a < AW'(MEM_BYTES)) write_ref(a, wbuf[k], sbuf[k]);
      else err = 1'b1;
    end
    wvalid = 0; wlast = 0;
    chk({tag, "_wready_done"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 1);
    for (int s = 0; s < bstall; s++) begin
      step();
      chk($sformatf("%s_bhold%0d", tag, s), bvalid, 1);
    end
    chk({tag, "_bid"}, bid, id);
    chk({tag, "_bresp"}, bresp, err ? 2'b10 : 2'b00);
    bready = 1;
    step();
    bready = 0;
    chk({tag, "_bvalid_clr"}, bvalid, 0);
    chk({tag, "_awready_back"}, awready, 1);
  endtask

  task automatic axi_read(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int max_stall);
    logic legal, ok;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    int st;
    legal = (size == 3'd2) && (burst == 2'b00 || burst == 2'b01);
    chk({tag, "_arready"}, arready, 1);
    arvalid = 1; arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
    rready = 0;
    step();
    arvalid = 0;
    for (int k = 0; k <= len; k++) begin
      a = (burst == 2'b00) ? addr : addr + AW'(k * NB);
      ok = legal && a < AW'(MEM_BYTES);
      exp_d = ok ? ref_mem[a / NB] : '0;
      st = (k == stall_beat) ? 5 : (max_stall > 0 ? int'($urandom_range(0, max_stall)) : 0);
      for (int s = 0; s < st; s++) begin
        chk($sformatf("%s_hold_rdata%0d_%0d", tag, k, s), rdata, exp_d);
        chk($sformatf("%s_hold_rlast%0d_%0d", tag, k, s), rlast, (k == len));
        step();
      end
      if (k == 0) rd_first = rdata;
      chk($sformatf("%s_rvalid%0d", tag, k), rvalid, 1);
      chk($sformatf("%s_rdata%0d", tag, k), rdata, exp_d);
      chk($sformatf("%s_rresp%0d", tag, k), rresp, ok ? 2'b00 : 2'b10);
      chk($sformatf("%s_rlast%0d", tag, k), rlast, (k == len));
      chk($sformatf("%s_rid%0d", tag, k), rid, id);
      rready = 1;
      step();
      rready = 0;
    end
    chk({tag, "_rvalid_clr"}, rvalid, 0);
    chk({tag, "_arready_back"}, arready, 1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    rb;
    logic [2:0]    rs;
    int            rl, pick;

    // Reset values
    rst_n = 0;
    step(); step();
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    rst_n = 1;
    step();

    // Give every word a known value
    fill_buf(63, '0, 1'b1);
    axi_write("fill", 4'd0, 32'h0, 63, 3'd2, 2'b01, -1, 0);

    // Single write then read
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = '1;
    axi_write("single_w", 4'd3, 32'h10, 0, 3'd2, 2'b01, -1, 0);
    axi_read("single_r", 4'd3, 32'h10, 0, 3'd2, 2'b01, -1, 0);
    chk("single_value", rd_first, 32'hDEADBEEF);

    // INCR burst, full-rate readback
    fill_buf(3, 32'd1, 1'b0);
    axi_write("incr_w", 4'd1, 32'h0, 3, 3'd2, 2'b01, -1, 0);
    axi_read("incr_r", 4'd2, 32'h0, 3, 3'd2, 2'b01, -1, 0);
    chk("incr_first", rd_first, 32'd1);

    // FIXED burst keeps the last beat
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    axi_write("fixed_w", 4'd4, 32'h20, 2, 3'd2, 2'b00, -1, 0);
    axi_read("fixed_r", 4'd4, 32'h20, 1, 3'd2, 2'b00, -1, 0);
    chk("fixed_value", rd_first, 32'hC);

    // Error cases: out-of-range write must not alias onto word 0
    wbuf[0] = 32'h5A5A5A5A; sbuf[0] = '1;
    axi_write("oor_w", 4'd5, 32'h100, 0, 3'd2, 2'b01, -1, 0);
    axi_read("oor_check", 4'd5, 32'h0, 0, 3'd2, 2'b01, -1, 0);
    axi_read("wrap_r", 4'd6, 32'h8, 1, 3'd2, 2'b10, -1, 0);
    fill_buf(1, 32'h77, 1'b0);
    axi_write("badlast_w", 4'd7, 32'h30, 1, 3'd2, 2'b01, 0, 0);
    axi_read("badsize_r", 4'd8, 32'h30, 0, 3'd1, 2'b01, -1, 0);

    // Backpressure
    axi_read("stall_r", 4'd9, 32'h40, 3, 3'd2, 2'b01, 2, 0);
    wbuf[0] = 32'h12345678; sbuf[0] = '1;
    axi_write("bstall_w", 4'd10, 32'h44, 0, 3'd2, 2'b01, -1, 4);

    // Strobes
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    axi_write("strb_init", 4'd2, 32'h30, 0, 3'd2, 2'b01, -1, 0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    axi_write("strb_w", 4'd2, 32'h30, 0, 3'd2, 2'b01, -1, 0);
    axi_read("strb_r", 4'd2, 32'h30, 0, 3'd2, 2'b01, -1, 0);
`ifdef EASYAXI_MEM_SLV_WSTRB_EN
    chk("strb_value", rd_first, 32'h11BB33DD);
`else
    chk("strb_value", rd_first, 32'hAABBCCDD);
`endif

    // Same-cycle write and read of one word: read sees the old contents
    awvalid = 1; awid = 4'd11; awaddr = 32'h80; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    step();
    awvalid = 0;
    wvalid = 1; wdata = 32'hCAFE0001; wstrb = '1; wlast = 1;
    arvalid = 1; arid = 4'd12; araddr = 32'h80; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    chk("raw_wready", wready, 1);
    chk("raw_arready", arready, 1);
    step();
    wvalid = 0; wlast = 0; arvalid = 0;
    chk("raw_rdata_old", rdata, ref_mem[32]);
    chk("raw_rvalid", rvalid, 1);
    chk("raw_bvalid", bvalid, 1);
    write_ref(32'h80, 32'hCAFE0001, 4'hF);
    rready = 1; bready = 1;
    step();
    rready = 0; bready = 0;
    chk("raw_rvalid_clr", rvalid, 0);
    chk("raw_bvalid_clr", bvalid, 0);
    axi_read("raw_after", 4'd12, 32'h80, 0, 3'd2, 2'b01, -1, 0);

    // Reset during beat 2 of a len=7 read
    arvalid = 1; arid = 4'd13; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    step();
    arvalid = 0; rready = 1;
    step(); step();
    rready = 0;
    chk("rstrd_beat2", rdata, ref_mem[2]);
    rst_n = 0;
    step();
    chk("rstrd_rvalid", rvalid, 0);
    chk("rstrd_arready", arready, 1);
    chk("rstrd_rlast", rlast, 0);
    rst_n = 1;
    step();

    // Reset mid write: words already written persist, no B is issued
    fill_buf(3, 32'hF00, 1'b0);
    awvalid = 1; awid = 4'd14; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    step();
    awvalid = 0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1; wdata = wbuf[k]; wstrb = '1; wlast = 0;
      step();
      write_ref(32'h40 + 32'(k * NB), wbuf[k], 4'hF);
    end
    wvalid = 0;
    rst_n = 0;
    step();
    chk("rstwr_bvalid", bvalid, 0);
    chk("rstwr_wready", wready, 0);
    chk("rstwr_awready", awready, 1);
    rst_n = 1;
    step();
    chk("rstwr_bvalid_after", bvalid, 0);
    axi_read("rstwr_check", 4'd14, 32'h40, 3, 3'd2, 2'b01, -1, 0);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      rl = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      rb = (pick < 7) ? 2'b01 : (pick < 9 ? 2'b00 : 2'b10);
      rs = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      ra = AW'($urandom_range(0, 71) * 4 + $urandom_range(0, 3));
      for (int k = 0; k <= rl; k++) begin
        wbuf[k] = DW'($urandom);
        sbuf[k] = NB'($urandom);
      end
      axi_write($sformatf("rnd_w%0d", it), IW'($urandom), ra, rl, rs, rb, -1,
                int'($urandom_range(0, 2)));
      rl = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      rb = (pick < 7) ? 2'b01 : (pick < 9 ? 2'b00 : 2'b10);
      rs = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      ra = AW'($urandom_range(0, 71) * 4 + $urandom_range(0, 3));
      axi_read($sformatf("rnd_r%0d", it), IW'($urandom), ra, rl, rs, rb, -1, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
